// File: rtl/alu_serial_pkg.sv
// Shared opcodes, FSM state, slice selects and operation decode for the bit-serial ALU.
// Define ALU_SERIAL_SLT_EN to enable set-less-than (0111); otherwise 0111 is unsupported.
package alu_serial_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_ADD2 = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SL_AND = 2'd0;
  localparam logic [1:0] SL_OR  = 2'd1;
  localparam logic [1:0] SL_ADD = 2'd2;
  localparam logic [1:0] SL_NOR = 2'd3;

  // inv_b doubles as the initial carry: only the a + ~b + 1 forms start with carry 1.
  typedef struct packed {
    logic       valid;
    logic       arith;
    logic       slt;
    logic       inv_b;
    logic [1:0] sop;
  } op_ctl_t;

  function automatic op_ctl_t decode_op(input logic [3:0] code);
    op_ctl_t c;
    c = '0;
    case (code)
      OP_AND: begin c.valid = 1'b1; c.sop = SL_AND; end
      OP_OR:  begin c.valid = 1'b1; c.sop = SL_OR;  end
      OP_NOR: begin c.valid = 1'b1; c.sop = SL_NOR; end
      OP_ADD, OP_ADD2: begin
        c.valid = 1'b1; c.arith = 1'b1; c.sop = SL_ADD;
      end
      OP_SUB: begin
        c.valid = 1'b1; c.arith = 1'b1; c.inv_b = 1'b1; c.sop = SL_ADD;
      end
`ifdef ALU_SERIAL_SLT_EN
      OP_SLT: begin
        c.valid = 1'b1; c.slt = 1'b1; c.inv_b = 1'b1; c.sop = SL_ADD;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_1.sv
// One-bit ALU slice: AND / OR / full-add / NOR on single bits with carry in and out.
module alu_1 (
  input  logic       a,
  input  logic       b,
  input  logic       carry_in,
  input  logic [1:0] op,
  output logic       result,
  output logic       carry_out
);

  assign carry_out = (a & b) | (carry_in & (a ^ b));

  always_comb begin
    result = 1'b0;
    case (op)
      2'd0:    result = a & b;
      2'd1:    result = a | b;
      2'd2:    result = a ^ b ^ carry_in;
      default: result = ~(a | b);
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU: one alu_1 slice processes operands LSB first over WIDTH cycles.
// Optional SLT support is enabled by defining ALU_SERIAL_SLT_EN (see alu_serial_pkg).
module alu_serial_seq
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in_0,
  input  logic [WIDTH-1:0] data_in_1,
  input  logic [3:0]       alu_control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-2:0] sh_q;
  op_ctl_t          ctl_q, ctl_new;
  logic             carry_q;

  logic             accept, last;
  logic             bit_a, bit_b, slice_res, slice_cout;
  logic             msb_ovf;
  logic [WIDTH-1:0] sum_full, fin_res;

  // Handshake: start is taken on any edge where the FSM is not in RUN; done is a
  // one-cycle pulse and result/flags stay valid until the next accepted start.
  assign accept    = start && (state_q != ST_RUN);
  assign last      = (state_q == ST_RUN) && (cnt_q == CW'(WIDTH - 1));
  assign ctl_new   = decode_op(alu_control);
  assign state_dbg = state_q;

  assign bit_a = a_q[cnt_q];
  assign bit_b = b_q[cnt_q] ^ ctl_q.inv_b;

  alu_1 u_slice (
    .a         (bit_a),
    .b         (bit_b),
    .carry_in  (carry_q),
    .op        (ctl_q.sop),
    .result    (slice_res),
    .carry_out (slice_cout)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = start ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Final-bit view: carry_q is the carry into the MSB, slice_cout the carry out of it.
  assign msb_ovf  = carry_q ^ slice_cout;
  assign sum_full = {slice_res, sh_q};

  always_comb begin
    fin_res = '0;
    if (ctl_q.valid) begin
      if (ctl_q.slt) fin_res = {{(WIDTH-1){1'b0}}, slice_res ^ msb_ovf};
      else           fin_res = sum_full;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sh_q      <= '0;
      ctl_q     <= '0;
      carry_q   <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_q     <= data_in_0;
      b_q     <= data_in_1;
      ctl_q   <= ctl_new;
      carry_q <= ctl_new.inv_b;
      cnt_q   <= '0;
    end else if (state_q == ST_RUN) begin
      sh_q    <= {slice_res, sh_q[WIDTH-2:1]};
      carry_q <= slice_cout;
      cnt_q   <= cnt_q + CW'(1);
      if (last) begin
        result    <= fin_res;
        zero      <= (fin_res == '0);
        carry_out <= ctl_q.arith & slice_cout;
        overflow  <= ctl_q.arith & msb_ovf;
      end
    end
  end

endmodule

// File: doc/alu_serial_seq.md
ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin one operation.
REQ-005 SHALL have port data_in_0  input  WIDTH  first operand.
REQ-006 SHALL have port data_in_1  input  WIDTH  second operand.
REQ-007 SHALL have port alu_control  input  4  operation select.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when result is valid.
REQ-010 SHALL have port result  output  WIDTH  operation result.
REQ-011 SHALL have port zero  output  1  result equals zero.
REQ-012 SHALL have port carry_out  output  1  carry out of the MSB slice.
REQ-013 SHALL have port overflow  output  1  signed overflow, add/sub only.

Function
REQ-014 SHALL use FSM IDLE -> RUN -> DONE; DONE -> RUN if start, else IDLE.
REQ-015 SHALL accept start only in IDLE or DONE; latch operands and alu_control on acceptance; ignore start in RUN.
REQ-016 SHALL process one bit per cycle in RUN, LSB first, bit counter 0..WIDTH-1; RUN lasts exactly WIDTH cycles.
REQ-017 SHALL assert done for one cycle in DONE (start edge + WIDTH + 1 edges; 33 cycles at WIDTH=32).
REQ-018 SHALL set busy = 1 in RUN only.
REQ-019 SHALL decode: 0000 AND, 0001 OR, 0010 add, 0011 add, 0110 sub, 1100 NOR, 0111 SLT (see REQ-027).
REQ-020 SHALL implement sub and SLT as a + ~b with initial carry 1; add with initial carry 0; logical ops ignore carry.
REQ-021 SHALL register the slice carry each bit and feed it to the next bit.
REQ-022 SHALL set overflow = carry into MSB XOR carry out of MSB for add/sub, else 0.
REQ-023 SHALL produce result 0, carry_out 0, overflow 0, zero 1 for unsupported codes, with normal timing.
REQ-024 SHALL hold result, zero, carry_out, overflow stable from DONE until the next accepted start.
REQ-025 SHALL compute zero from the final result, not the slice zero output.

Reset
REQ-026 SHALL, on reset_n low at any time including mid-RUN, force IDLE, counter 0, busy 0, done 0, result 0, zero 0, carry_out 0, overflow 0; no done pulse for the aborted operation.

Configuration
REQ-027 SHALL, with ALU_SERIAL_SLT_EN defined, return SLT result = {WIDTH-1 zeros, MSB-of-difference XOR overflow}, carry_out and overflow 0.
REQ-028 SHALL, without ALU_SERIAL_SLT_EN, treat 0111 as unsupported (REQ-023).

Structure
REQ-029 SHALL place opcode constants, FSM state enum and the default WIDTH in package alu_serial_pkg.
REQ-030 SHALL instantiate exactly one existing alu_1 slice as its only sub-module; operand inversion and carry register live in alu_serial_seq.

Verification
REQ-031 SHALL cover add 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow 1, carry_out 0, done 33 cycles after start.
REQ-032 SHALL cover sub 0x00000005 - 0x00000005 -> result 0, zero 1, carry_out 1, overflow 0.
REQ-033 SHALL cover NOR 0x00000000, 0x00000000 -> result 0xFFFFFFFF, zero 0.
REQ-034 SHALL cover SLT 0xFFFFFFFF vs 0x00000001 -> result 1 with ALU_SERIAL_SLT_EN, 0 without.
REQ-035 SHALL cover reset_n pulsed low at bit 10 of an add -> busy 0, all outputs 0, no done; start pulse during RUN ignored.
REQ-036 SHALL cover start held high in the DONE cycle -> second operation begins with no IDLE cycle, done again 33 cycles later.
